iir_biquad_scheduler: RTL and testbench

Time-multiplexed controller for a cascade of `N_SECT` second-order IIR sections in the detector backend. It shares one 11×12 multiplier/accumulator across all sections and all five taps, instead of instantiating one parallel section per stage. It sequences the taps, holds per-section history and run-time-writable coefficients, and exchanges samples with up- and downstream logic through valid/ready handshakes. Its arithmetic is bit-exact with the existing parallel single-section datapath.

---
 rtl/iir_biquad_scheduler_pkg.sv | 42 ++++
 rtl/iir_biquad_scheduler_if.sv | 26 ++
 rtl/iir_biquad_scheduler_mac.sv | 39 +++
 rtl/iir_biquad_scheduler.sv | 171 +++++++++++++++++
 tb/tb_iir_biquad_scheduler.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/iir_biquad_scheduler_pkg.sv
// Shared types, constants and the tap/state enums for the time-multiplexed biquad cascade.
package iir_pkg;

  typedef logic signed [10:0] sample_t;
  typedef logic signed [11:0] coef_t;
  typedef logic signed [22:0] acc_t;

  localparam int ROUND_CONST = 512;

  localparam coef_t DEF_B0  = 12'sd28;
  localparam coef_t DEF_B1  = 12'sd33;
  localparam coef_t DEF_B2  = 12'sd28;
  localparam coef_t DEF_MA1 = 12'sd1577;
  localparam coef_t DEF_MA2 = -12'sd658;

  typedef enum logic [2:0] {
    TAP_B0  = 3'd0,
    TAP_B1  = 3'd1,
    TAP_B2  = 3'd2,
    TAP_MA1 = 3'd3,
    TAP_MA2 = 3'd4
  } tap_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  function automatic coef_t default_coef(input logic [2:0] idx);
    case (idx)
      3'd0:    default_coef = DEF_B0;
      3'd1:    default_coef = DEF_B1;
      3'd2:    default_coef = DEF_B2;
      3'd3:    default_coef = DEF_MA1;
      3'd4:    default_coef = DEF_MA2;
      default: default_coef = 12'sd0;
    endcase
  endfunction

endpackage

// File: rtl/iir_biquad_scheduler_if.sv
// Sample-in, sample-out and coefficient-write handshakes of the biquad scheduler.
interface iir_biquad_scheduler_if;
  import iir_pkg::*;

  logic        in_valid;
  logic        in_ready;
  sample_t     in_x;
  logic        out_valid;
  logic        out_ready;
  sample_t     out_y;
  logic        cfg_we;
  logic [2:0]  cfg_sec;
  logic [2:0]  cfg_idx;
  coef_t       cfg_data;
  logic        cfg_ready;

  modport master (
    output in_valid, in_x, out_ready, cfg_we, cfg_sec, cfg_idx, cfg_data,
    input  in_ready, out_valid, out_y, cfg_ready
  );

  modport slave (
    input  in_valid, in_x, out_ready, cfg_we, cfg_sec, cfg_idx, cfg_data,
    output in_ready, out_valid, out_y, cfg_ready
  );
endinterface

// File: rtl/iir_biquad_scheduler_mac.sv
// Shared 11x12 multiply-accumulate with Q3.20 accumulator and rounded Q1.10 output.
module iir_mac
  import iir_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  sample_t op_i,
  input  coef_t   coef_i,
  input  logic    clr_i,
  input  logic    en_i,
  output sample_t y_o
);

  acc_t acc_q;
  acc_t acc_d;
  acc_t prod;

  always_comb begin
    prod  = acc_t'(op_i) * acc_t'(coef_i);
    acc_d = acc_q;
    if (en_i) begin
      acc_d = clr_i ? prod : acc_q + prod;
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= 23'sd0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Only the low 21 bits take part in rounding; overflow wraps like the parallel section.
  assign y_o = sample_t'((acc_q[20:0] + 21'(ROUND_CONST)) >> 10);

endmodule

// File: rtl/iir_biquad_scheduler.sv
// Biquad cascade controller: FSM, per-section history and coefficient file around one shared MAC.
module iir_biquad_scheduler
  import iir_pkg::*;
#(
  parameter int N_SECT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  iir_biquad_scheduler_if.slave  bus
);

  localparam int         SW        = (N_SECT > 1) ? $clog2(N_SECT) : 1;
  localparam logic [2:0] LAST_SEC  = 3'(N_SECT - 1);
  localparam logic [3:0] N_SECT_W  = 4'(N_SECT);

  state_e     state_q, state_d;
  logic [2:0] sec_q, sec_d;
  tap_e       tap_q, tap_d;
  sample_t    cur_q, cur_d;
  sample_t    out_y_q, out_y_d;
  logic       out_valid_q, out_valid_d;

  sample_t xn1_q [N_SECT];
  sample_t xn1_d [N_SECT];
  sample_t xn2_q [N_SECT];
  sample_t xn2_d [N_SECT];
  sample_t yn1_q [N_SECT];
  sample_t yn1_d [N_SECT];
  sample_t yn2_q [N_SECT];
  sample_t yn2_d [N_SECT];
  coef_t   coef_q [N_SECT][5];
  coef_t   coef_d [N_SECT][5];

  logic [SW-1:0] sec_i;
  sample_t       mac_op;
  coef_t         mac_coef;
  sample_t       y0;
  logic          idle;
  logic          cfg_ok;

  assign sec_i  = sec_q[SW-1:0];
  assign idle   = (state_q == ST_IDLE) && !rst;
  assign cfg_ok = bus.cfg_we && idle && (bus.cfg_idx <= 3'd4) && ({1'b0, bus.cfg_sec} < N_SECT_W);

  iir_mac u_mac (
    .clk    (clk),
    .rst    (rst),
    .op_i   (mac_op),
    .coef_i (mac_coef),
    .clr_i  (tap_q == TAP_B0),
    .en_i   (state_q == ST_MAC),
    .y_o    (y0)
  );

  always_comb begin
    state_d     = state_q;
    sec_d       = sec_q;
    tap_d       = tap_q;
    cur_d       = cur_q;
    out_y_d     = out_y_q;
    out_valid_d = out_valid_q;
    xn1_d       = xn1_q;
    xn2_d       = xn2_q;
    yn1_d       = yn1_q;
    yn2_d       = yn2_q;
    coef_d      = coef_q;

    mac_coef = coef_q[sec_i][tap_q];
    case (tap_q)
      TAP_B0:  mac_op = cur_q;
      TAP_B1:  mac_op = xn1_q[sec_i];
      TAP_B2:  mac_op = xn2_q[sec_i];
      TAP_MA1: mac_op = yn1_q[sec_i];
      TAP_MA2: mac_op = yn2_q[sec_i];
      default: mac_op = 11'sd0;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          cur_d   = bus.in_x;
          sec_d   = 3'd0;
          tap_d   = TAP_B0;
          state_d = ST_MAC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MAC: begin
        if (tap_q == TAP_MA2) begin
          state_d = ST_ROUND;
        end else begin
          tap_d = tap_e'(tap_q + 3'd1);
        end
      end
      ST_ROUND: begin
        xn2_d[sec_i] = xn1_q[sec_i];
        xn1_d[sec_i] = cur_q;
        yn2_d[sec_i] = yn1_q[sec_i];
        yn1_d[sec_i] = y0;
        if (sec_q < LAST_SEC) begin
          cur_d   = y0;
          sec_d   = sec_q + 3'd1;
          tap_d   = TAP_B0;
          state_d = ST_MAC;
        end else begin
          out_y_d     = y0;
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // A write landing with an input accept is seen by that sample's first MAC cycle.
    if (cfg_ok) begin
      coef_d[bus.cfg_sec[SW-1:0]][bus.cfg_idx] = bus.cfg_data;
    end else begin
      coef_d = coef_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sec_q       <= 3'd0;
      tap_q       <= TAP_B0;
      cur_q       <= 11'sd0;
      out_y_q     <= 11'sd0;
      out_valid_q <= 1'b0;
      for (int s = 0; s < N_SECT; s++) begin
        xn1_q[s] <= 11'sd0;
        xn2_q[s] <= 11'sd0;
        yn1_q[s] <= 11'sd0;
        yn2_q[s] <= 11'sd0;
        for (int t = 0; t < 5; t++) begin
          coef_q[s][t] <= default_coef(3'(t));
        end
      end
    end else begin
      state_q     <= state_d;
      sec_q       <= sec_d;
      tap_q       <= tap_d;
      cur_q       <= cur_d;
      out_y_q     <= out_y_d;
      out_valid_q <= out_valid_d;
      xn1_q       <= xn1_d;
      xn2_q       <= xn2_d;
      yn1_q       <= yn1_d;
      yn2_q       <= yn2_d;
      coef_q      <= coef_d;
    end
  end

  assign bus.in_ready  = idle;
  assign bus.cfg_ready = idle;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;

endmodule

// File: tb/tb_iir_biquad_scheduler.sv
// Randomized and directed checks of the biquad scheduler against a plain-arithmetic cascade model.
module tb_iir_biquad_scheduler;
  import iir_pkg::*;

  localparam int NS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iir_biquad_scheduler_if bus ();

  iir_biquad_scheduler #(.N_SECT(NS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int ncmp  = 0;
  int nfail = 0;

  int cm  [NS][5];
  int mx1 [NS];
  int mx2 [NS];
  int my1 [NS];
  int my2 [NS];

  task automatic chk(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int wrap11(input int v);
    int r;
    r = v & 32'h7FF;
    if (r >= 1024) r = r - 2048;
    return r;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < NS; s++) begin
      cm[s][0] = 28; cm[s][1] = 33; cm[s][2] = 28; cm[s][3] = 1577; cm[s][4] = -658;
      mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
    end
  endfunction

  // Direct-form-I biquad per section; rounding keeps bits [20:10] of acc+512 with wrap.
  function automatic int model_step(input int x);
    int cur, acc, y;
    cur = x;
    for (int s = 0; s < NS; s++) begin
      acc = cm[s][0]*cur + cm[s][1]*mx1[s] + cm[s][2]*mx2[s] + cm[s][3]*my1[s] + cm[s][4]*my2[s];
      y = wrap11((acc + 512) >>> 10);
      mx2[s] = mx1[s]; mx1[s] = cur;
      my2[s] = my1[s]; my1[s] = y;
      cur = y;
    end
    return cur;
  endfunction

  task automatic do_cfg(input int sec, input int idx, input int data, input bit expect_apply);
    bus.cfg_we   = 1'b1;
    bus.cfg_sec  = 3'(sec);
    bus.cfg_idx  = 3'(idx);
    bus.cfg_data = 12'(data);
    chk("cfg_ready", int'(bus.cfg_ready), 1);
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    if (expect_apply) cm[sec][idx] = data;
  endtask

  task automatic do_sample(input int x, input int hold, input bit sw, input int ssec,
                           input int sidx, input int sdata, input bit mac_wr);
    int lat, exp;
    bus.in_valid = 1'b1;
    bus.in_x     = 11'(x);
    if (sw) begin
      bus.cfg_we = 1'b1; bus.cfg_sec = 3'(ssec); bus.cfg_idx = 3'(sidx); bus.cfg_data = 12'(sdata);
      cm[ssec][sidx] = sdata;
    end
    chk("in_ready_idle", int'(bus.in_ready), 1);
    exp = model_step(x);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      if (mac_wr && lat == 2) begin
        bus.cfg_we = 1'b1; bus.cfg_sec = 3'd0; bus.cfg_idx = 3'd0; bus.cfg_data = 12'sd0;
      end else begin
        bus.cfg_we = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.cfg_we = 1'b0;
    chk("latency", lat, 6*NS);
    chk("out_y", int'(bus.out_y), exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_out_y", int'(bus.out_y), exp);
      chk("hold_in_ready", int'(bus.in_ready), 0);
      chk("hold_out_valid", int'(bus.out_valid), 1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("out_valid_drop", int'(bus.out_valid), 0);
    chk("in_ready_back", int'(bus.in_ready), 1);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_x = 11'sd0; bus.out_ready = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_sec = 3'd0; bus.cfg_idx = 3'd0; bus.cfg_data = 12'sd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_y", int'(bus.out_y), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_cfg_ready", int'(bus.cfg_ready), 1);

    // Full-scale impulse (1024 wraps to -1024 in Q1.10) then zeros.
    do_sample(-1024, 0, 1'b0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 63; i++) do_sample(0, 0, 1'b0, 0, 0, 0, 1'b0);

    do_sample(int'($urandom_range(0, 2047)) - 1024, 5, 1'b0, 0, 0, 0, 1'b0);

    do_cfg(1, 0, 1024, 1'b1);
    for (int i = 0; i < 4; i++) do_sample(100, 0, 1'b0, 0, 0, 0, 1'b0);

    do_sample(300, 0, 1'b0, 0, 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) do_sample(250, 0, 1'b0, 0, 0, 0, 1'b0);

    do_cfg(1, 6, 777, 1'b0);
    do_cfg(3, 0, 555, 1'b0);
    for (int i = 0; i < 3; i++) do_sample(-400, 0, 1'b0, 0, 0, 0, 1'b0);

    do_sample(500, 0, 1'b1, 0, 0, 0, 1'b0);
    do_sample(500, 0, 1'b0, 0, 0, 0, 1'b0);

    do_cfg(0, 3, 2047, 1'b1);
    do_cfg(1, 3, 2047, 1'b1);
    for (int i = 0; i < 20; i++) do_sample(1023, 0, 1'b0, 0, 0, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0)
        do_cfg(int'($urandom_range(0, NS-1)), int'($urandom_range(0, 4)),
               int'($urandom_range(0, 4095)) - 2048, 1'b1);
      do_sample(int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 2)),
                1'b0, 0, 0, 0, 1'b0);
    end

    // Reset in the middle of the first section's MAC phase.
    bus.in_valid = 1'b1; bus.in_x = 11'sd200;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_in_ready", int'(bus.in_ready), 0);
    chk("midrst_out_y", int'(bus.out_y), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk("postrst_in_ready", int'(bus.in_ready), 1);
    do_sample(-1024, 0, 1'b0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 15; i++) do_sample(0, 0, 1'b0, 0, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
